// File: rtl/debug_step_ctrl.sv
// Debug step/run controller: decodes UART command bytes, gates the pipeline step
// enable and streams a PC (or step-count with DEBUG_CYCLE_CNT_EN) out as 4 bytes.
module debug_step_ctrl #(
    parameter int PC_W  = 32,
    parameter int CMD_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_cmd_valid,
    input  logic [CMD_W-1:0] i_cmd,
    input  logic             i_halt,
    input  logic [PC_W-1:0]  i_pc,
    input  logic             i_tx_ready,
    output logic             o_step,
    output logic             o_tx_valid,
    output logic [CMD_W-1:0] o_tx_data,
    output logic [2:0]       o_state
);

    localparam int SH_W = 4 * CMD_W;

    localparam logic [CMD_W-1:0] CMD_CONT  = CMD_W'(8'h63);
    localparam logic [CMD_W-1:0] CMD_STEP  = CMD_W'(8'h73);
    localparam logic [CMD_W-1:0] CMD_READ  = CMD_W'(8'h72);
    localparam logic [CMD_W-1:0] CMD_PAUSE = CMD_W'(8'h70);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_STEP = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_q;
    state_t            ret_q;
    logic              step_q;
    logic              tx_valid_q;
    logic [CMD_W-1:0]  tx_data_q;
    logic [1:0]        idx_q;
    logic [1:0]        idx_d;
    logic              load_q;
    logic [SH_W-1:0]   shadow_q;
    logic [SH_W-1:0]   load_src;

    logic cmd_cont, cmd_step, cmd_read, cmd_pause;

    assign cmd_cont  = i_cmd_valid && (i_cmd == CMD_CONT);
    assign cmd_step  = i_cmd_valid && (i_cmd == CMD_STEP);
    assign cmd_read  = i_cmd_valid && (i_cmd == CMD_READ);
    assign cmd_pause = i_cmd_valid && (i_cmd == CMD_PAUSE);

    assign idx_d = idx_q + 2'd1;

`ifdef DEBUG_CYCLE_CNT_EN
    localparam logic [CMD_W-1:0] CMD_COUNT = CMD_W'(8'h6B);

    logic        cmd_count;
    logic        src_cnt_q;
    logic [31:0] cnt_q;

    assign cmd_count = i_cmd_valid && (i_cmd == CMD_COUNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (step_q) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    always_comb begin
        load_src = SH_W'(i_pc);
        if (src_cnt_q) begin
            load_src = SH_W'(cnt_q);
        end
    end
`else
    always_comb begin
        load_src = SH_W'(i_pc);
    end
`endif

    function automatic logic [CMD_W-1:0] byte_of(input logic [SH_W-1:0] s, input logic [1:0] i);
        logic [CMD_W-1:0] b;
        case (i)
            2'd0:    b = s[0*CMD_W +: CMD_W];
            2'd1:    b = s[1*CMD_W +: CMD_W];
            2'd2:    b = s[2*CMD_W +: CMD_W];
            default: b = s[3*CMD_W +: CMD_W];
        endcase
        return b;
    endfunction

    // SEND spends its first cycle capturing the source, so a PC advanced by the
    // preceding STEP pulse is the value that gets reported.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ret_q      <= S_IDLE;
            step_q     <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            idx_q      <= 2'd0;
            load_q     <= 1'b0;
            shadow_q   <= '0;
`ifdef DEBUG_CYCLE_CNT_EN
            src_cnt_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    step_q <= 1'b0;
                    if (cmd_cont) begin
                        state_q <= S_RUN;
                        step_q  <= 1'b1;
                    end else if (cmd_step) begin
                        if (i_halt) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_STEP;
                            step_q  <= 1'b1;
                        end
                    end else if (cmd_read) begin
                        state_q <= S_SEND;
                        ret_q   <= S_IDLE;
                        load_q  <= 1'b1;
                        idx_q   <= 2'd0;
`ifdef DEBUG_CYCLE_CNT_EN
                        src_cnt_q <= 1'b0;
                    end else if (cmd_count) begin
                        state_q   <= S_SEND;
                        ret_q     <= S_IDLE;
                        load_q    <= 1'b1;
                        idx_q     <= 2'd0;
                        src_cnt_q <= 1'b1;
`endif
                    end
                end
                S_RUN: begin
                    if (i_halt) begin
                        state_q <= S_DONE;
                        step_q  <= 1'b0;
                    end else if (cmd_pause) begin
                        state_q <= S_IDLE;
                        step_q  <= 1'b0;
                    end else begin
                        step_q <= 1'b1;
                    end
                end
                S_STEP: begin
                    step_q  <= 1'b0;
                    state_q <= S_SEND;
                    ret_q   <= S_IDLE;
                    load_q  <= 1'b1;
                    idx_q   <= 2'd0;
`ifdef DEBUG_CYCLE_CNT_EN
                    src_cnt_q <= 1'b0;
`endif
                end
                S_SEND: begin
                    step_q <= 1'b0;
                    if (load_q) begin
                        load_q     <= 1'b0;
                        shadow_q   <= load_src;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= load_src[CMD_W-1:0];
                    end else if (tx_valid_q && i_tx_ready) begin
                        idx_q <= idx_d;
                        if (idx_q == 2'd3) begin
                            tx_valid_q <= 1'b0;
                            tx_data_q  <= '0;
                            state_q    <= ret_q;
                        end else begin
                            tx_data_q <= byte_of(shadow_q, idx_d);
                        end
                    end
                end
                S_DONE: begin
                    step_q <= 1'b0;
                    if (cmd_read) begin
                        state_q <= S_SEND;
                        ret_q   <= S_DONE;
                        load_q  <= 1'b1;
                        idx_q   <= 2'd0;
`ifdef DEBUG_CYCLE_CNT_EN
                        src_cnt_q <= 1'b0;
                    end else if (cmd_count) begin
                        state_q   <= S_SEND;
                        ret_q     <= S_DONE;
                        load_q    <= 1'b1;
                        idx_q     <= 2'd0;
                        src_cnt_q <= 1'b1;
`endif
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    step_q     <= 1'b0;
                    tx_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_step     = step_q;
    assign o_tx_valid = tx_valid_q;
    assign o_tx_data  = tx_data_q;
    assign o_state    = state_q;

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Bench for debug_step_ctrl: per-cycle vector table plus byte-stream scoreboard
// sequences for stalls, halt, mid-transfer reset and the optional step counter.
module tb_debug_step_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd = 8'h00;
    logic        halt = 1'b0;
    logic [31:0] pc = 32'h0000_0004;
    logic        tx_ready = 1'b1;
    logic        step;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic [2:0]  state;

    always #5 clk = ~clk;

    debug_step_ctrl #(.PC_W(32), .CMD_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_cmd_valid(cmd_valid),
        .i_cmd      (cmd),
        .i_halt     (halt),
        .i_pc       (pc),
        .i_tx_ready (tx_ready),
        .o_step     (step),
        .o_tx_valid (tx_valid),
        .o_tx_data  (tx_data),
        .o_state    (state)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       r;
        logic       cv;
        logic [7:0] c;
        logic       h;
        logic       es;
        logic       ev;
        logic [7:0] ed;
        logic [2:0] est;
    } vec_t;

    vec_t        vecs[17];
    vec_t        exp_q[$];
    logic [7:0]  tx_exp[$];

    function automatic vec_t mk(input logic r, input logic cv, input logic [7:0] c, input logic h,
                                input logic es, input logic ev, input logic [7:0] ed, input logic [2:0] est);
        vec_t v;
        v.r = r; v.cv = cv; v.c = c; v.h = h;
        v.es = es; v.ev = ev; v.ed = ed; v.est = est;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic r, input logic cv, input logic [7:0] c, input logic h);
        rst = r; cmd_valid = cv; cmd = c; halt = h;
    endtask

    // mode 0: ready always high; mode 1: ready follows 1,0,0,1,1,0,1 over offered cycles.
    task automatic run_send(input int mode, input logic [31:0] pc_after, input logic [2:0] ret_st,
                            input int stop_after);
        logic [6:0] pat;
        int         pat_i;
        bit         seen;
        bit         stalled;
        logic [7:0] held;
        int         sent;
        bit         finished;
        pat = 7'b1011001;
        pat_i = 0; seen = 0; stalled = 0; held = 8'h00; sent = 0; finished = 0;
        for (int n = 0; n < 60 && !finished; n++) begin
            cmd_valid = 1'b0;
            if (stalled) begin
                chk("stall valid", {31'd0, tx_valid}, 32'd1);
                chk("stall hold", {24'd0, tx_data}, {24'd0, held});
            end
            if (tx_valid && !seen) begin
                seen = 1;
                pc = pc_after;
            end
            tx_ready = (mode == 0) ? 1'b1 : pat[pat_i % 7];
            stalled = tx_valid && !tx_ready;
            held = tx_data;
            if (tx_valid && tx_ready) begin
                if (tx_exp.size() == 0) begin
                    chk("extra byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    chk("tx byte", {24'd0, tx_data}, {24'd0, tx_exp.pop_front()});
                end
                sent++;
            end
            if (tx_valid) pat_i++;
            tick();
            if (stop_after > 0 && sent == stop_after) finished = 1;
            else if (tx_exp.size() == 0 && sent > 0 && !tx_valid) finished = 1;
        end
        tx_ready = 1'b1;
        if (stop_after == 0) begin
            chk("bytes left", tx_exp.size(), 0);
            chk("send valid end", {31'd0, tx_valid}, 32'd0);
            chk("send return state", {29'd0, state}, {29'd0, ret_st});
        end
    endtask

    initial begin
        vec_t e;
        int   nstep;

        vecs[0]  = mk(1, 0, 8'h00, 0,  0, 0, 8'h00, 3'd0);
        vecs[1]  = mk(0, 1, 8'h78, 0,  0, 0, 8'h00, 3'd0);
        vecs[2]  = mk(0, 1, 8'h73, 0,  1, 0, 8'h00, 3'd2);
        vecs[3]  = mk(0, 0, 8'h00, 0,  0, 0, 8'h00, 3'd3);
        vecs[4]  = mk(0, 0, 8'h00, 0,  0, 1, 8'h04, 3'd3);
        vecs[5]  = mk(0, 1, 8'h63, 0,  0, 1, 8'h00, 3'd3);
        vecs[6]  = mk(0, 0, 8'h00, 0,  0, 1, 8'h00, 3'd3);
        vecs[7]  = mk(0, 0, 8'h00, 0,  0, 1, 8'h00, 3'd3);
        vecs[8]  = mk(0, 0, 8'h00, 0,  0, 0, 8'h00, 3'd0);
        vecs[9]  = mk(0, 1, 8'h63, 0,  1, 0, 8'h00, 3'd1);
        vecs[10] = mk(0, 0, 8'h00, 0,  1, 0, 8'h00, 3'd1);
        vecs[11] = mk(0, 1, 8'h70, 1,  0, 0, 8'h00, 3'd4);
        vecs[12] = mk(0, 1, 8'h73, 0,  0, 0, 8'h00, 3'd4);
        vecs[13] = mk(0, 1, 8'h63, 0,  0, 0, 8'h00, 3'd4);
        vecs[14] = mk(1, 0, 8'h00, 0,  0, 0, 8'h00, 3'd0);
`ifdef DEBUG_CYCLE_CNT_EN
        vecs[15] = mk(0, 1, 8'h6B, 0,  0, 0, 8'h00, 3'd3);
        vecs[16] = mk(0, 0, 8'h00, 0,  0, 1, 8'h00, 3'd3);
`else
        vecs[15] = mk(0, 1, 8'h6B, 0,  0, 0, 8'h00, 3'd0);
        vecs[16] = mk(0, 0, 8'h00, 0,  0, 0, 8'h00, 3'd0);
`endif

        tick();
        for (int i = 0; i < 17; i++) begin
            drv(vecs[i].r, vecs[i].cv, vecs[i].c, vecs[i].h);
            exp_q.push_back(vecs[i]);
            tick();
            e = exp_q.pop_front();
            chk($sformatf("row%0d step", i),  {31'd0, step},     {31'd0, e.es});
            chk($sformatf("row%0d valid", i), {31'd0, tx_valid}, {31'd0, e.ev});
            chk($sformatf("row%0d data", i),  {24'd0, tx_data},  {24'd0, e.ed});
            chk($sformatf("row%0d state", i), {29'd0, state},    {29'd0, e.est});
        end

        // 'r' with stalls; PC changes once bytes start and must not leak in
        drv(1, 0, 8'h00, 0); tick(); drv(0, 0, 8'h00, 0);
        pc = 32'hDEAD_BEEF;
        drv(0, 1, 8'h72, 0);
        tx_exp.push_back(8'hEF); tx_exp.push_back(8'hBE);
        tx_exp.push_back(8'hAD); tx_exp.push_back(8'hDE);
        tick();
        run_send(1, 32'h0000_0000, 3'd0, 0);

        // run, halt after 10 steps, then 's' ignored and 'r' returns to DONE
        drv(0, 1, 8'h63, 0);
        tick();
        nstep = 0;
        for (int i = 0; i < 10; i++) begin
            cmd_valid = 1'b0;
            nstep += int'(step);
            if (i == 9) halt = 1'b1;
            tick();
        end
        chk("run step count", nstep, 10);
        chk("halt step low", {31'd0, step}, 32'd0);
        chk("halt state", {29'd0, state}, 32'd4);
        drv(0, 1, 8'h73, 0);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("done no step", {31'd0, step}, 32'd0);
            tick();
        end
        chk("done state hold", {29'd0, state}, 32'd4);
        pc = 32'h0A0B_0C0D;
        drv(0, 1, 8'h72, 0);
        tx_exp.push_back(8'h0D); tx_exp.push_back(8'h0C);
        tx_exp.push_back(8'h0B); tx_exp.push_back(8'h0A);
        tick();
        run_send(0, 32'h0A0B_0C0D, 3'd4, 0);

        // reset after the second byte aborts the transfer
        drv(1, 0, 8'h00, 0); tick(); drv(0, 0, 8'h00, 0);
        pc = 32'h1122_3344;
        drv(0, 1, 8'h72, 0);
        tx_exp.push_back(8'h44); tx_exp.push_back(8'h33);
        tick();
        run_send(0, 32'h1122_3344, 3'd0, 2);
        drv(1, 0, 8'h00, 0);
        tick();
        chk("abort valid", {31'd0, tx_valid}, 32'd0);
        chk("abort state", {29'd0, state}, 32'd0);
        drv(0, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort quiet", {31'd0, tx_valid}, 32'd0);
        end
        tx_exp.delete();

        // step counter readback (or 'k' ignored in the default build)
        drv(1, 0, 8'h00, 0); tick(); drv(0, 0, 8'h00, 0);
        pc = 32'h1234_5678;
        drv(0, 1, 8'h63, 0);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        drv(0, 1, 8'h70, 0);
        tick();
        chk("pause state", {29'd0, state}, 32'd0);
        chk("pause step", {31'd0, step}, 32'd0);
        drv(0, 1, 8'h6B, 0);
`ifdef DEBUG_CYCLE_CNT_EN
        tx_exp.push_back(8'h05); tx_exp.push_back(8'h00);
        tx_exp.push_back(8'h00); tx_exp.push_back(8'h00);
        tick();
        run_send(0, 32'h1234_5678, 3'd0, 0);
`else
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("k ignored valid", {31'd0, tx_valid}, 32'd0);
            chk("k ignored state", {29'd0, state}, 32'd0);
            tick();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
